// File: rtl/click_sync_bridge.sv
`timescale 1ns/1ps
// Clocked bridge into/out of the click-element ring: 2-phase request on the IF
// side, 2-phase acknowledge on the WB side, in-flight tracking and controlled drain.
module click_sync_bridge #(
  parameter int MAX_TOKENS  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enable,
  input  logic             i_launch_valid,
  output logic             o_launch_ready,
  output logic             o_reqL,
  input  logic             i_ackL,
  input  logic             i_reqR,
  output logic             o_ackR,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic [3:0]       o_inflight,
  output logic             o_busy,
  output logic             o_drained,
  output logic             o_err
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  localparam logic [3:0] MAXT = 4'(MAX_TOKENS);

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_ackL_sync, r_reqR_sync;
  logic                   r_reqR_d, r_reqL, r_ackR, r_retire, r_drained, r_err;
  logic [3:0]             r_inflight, w_inflight_nxt;
  logic [CNT_W-1:0]       r_retire_cnt;

  logic w_ackL_s, w_reqR_s, w_quiet, w_ackL_tog, w_retire, w_launch, w_drain_done;

  assign w_ackL_s   = r_ackL_sync[SYNC_STAGES-1];
  assign w_reqR_s   = r_reqR_sync[SYNC_STAGES-1];
  assign w_quiet    = (r_reqL == w_ackL_s);
  // Toggle about to land in ackL_s; legal only while a left request is pending.
  assign w_ackL_tog = r_ackL_sync[SYNC_STAGES-1] != r_ackL_sync[SYNC_STAGES-2];
  assign w_retire   = w_reqR_s != r_reqR_d;

  assign o_launch_ready = (r_state == ST_RUN) && w_quiet && (r_inflight < MAXT);
  assign w_launch       = i_launch_valid && o_launch_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_done = (r_state == ST_DRAIN) && (r_inflight == 4'd0) && w_quiet;
    case (r_state)
      ST_IDLE:  if (i_enable)     w_state_nxt = ST_RUN;
      ST_RUN:   if (!i_enable)    w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_launch, w_retire})
      2'b10:   w_inflight_nxt = r_inflight + 4'd1;
      2'b01:   if (r_inflight != 4'd0) w_inflight_nxt = r_inflight - 4'd1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ackL_sync  <= '0;
      r_reqR_sync  <= '0;
      r_reqR_d     <= 1'b0;
      r_reqL       <= 1'b0;
      r_ackR       <= 1'b0;
      r_retire     <= 1'b0;
      r_retire_cnt <= '0;
      r_inflight   <= 4'd0;
      r_drained    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ackL_sync <= {r_ackL_sync[SYNC_STAGES-2:0], i_ackL};
      r_reqR_sync <= {r_reqR_sync[SYNC_STAGES-2:0], i_reqR};
      r_reqR_d    <= w_reqR_s;
      r_retire    <= w_retire;
      r_drained   <= w_drain_done;
      r_inflight  <= w_inflight_nxt;
      if (w_launch) r_reqL <= ~r_reqL;
      if (w_retire) begin
        r_ackR       <= w_reqR_s;
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      // Retire with nothing in flight, or an acknowledge nobody asked for.
      if ((w_retire && r_inflight == 4'd0) || (w_ackL_tog && w_quiet)) r_err <= 1'b1;
    end
  end

  assign o_reqL       = r_reqL;
  assign o_ackR       = r_ackR;
  assign o_retire     = r_retire;
  assign o_retire_cnt = r_retire_cnt;
  assign o_inflight   = r_inflight;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_drained    = r_drained;
  assign o_err        = r_err;

endmodule

// File: tb/tb_click_sync_bridge.sv
`timescale 1ns/1ps
// Bench for click_sync_bridge: ring environment model plus a retire scoreboard
// that predicts count, acknowledge value and arrival cycle of every retire.
module tb_click_sync_bridge;
  localparam int CW = 4;
  localparam int SBN = 1024;

  logic i_clk = 1'b0, i_rstn = 1'b0, i_enable = 1'b0, i_launch_valid = 1'b0;
  logic i_ackL = 1'b0, i_reqR = 1'b0;
  logic o_launch_ready, o_reqL, o_ackR, o_retire, o_busy, o_drained, o_err;
  logic [CW-1:0] o_retire_cnt;
  logic [3:0]    o_inflight;

  click_sync_bridge #(.MAX_TOKENS(4), .SYNC_STAGES(2), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_launch_valid(i_launch_valid),
    .o_launch_ready(o_launch_ready), .o_reqL(o_reqL), .i_ackL(i_ackL), .i_reqR(i_reqR),
    .o_ackR(o_ackR), .o_retire(o_retire), .o_retire_cnt(o_retire_cnt),
    .o_inflight(o_inflight), .o_busy(o_busy), .o_drained(o_drained), .o_err(o_err));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: stimulus side writes entries, monitor consumes them.
  int sb_cnt[SBN], sb_due[SBN];
  bit sb_ack[SBN];
  int wr_ptr = 0, rd_ptr = 0;
  int mcnt = 0;

  always @(negedge i_clk) begin
    if (!i_rstn) rd_ptr = wr_ptr;
    else if (o_retire) begin
      if (rd_ptr == wr_ptr) chk("unexpected_retire", o_retire, 0);
      else begin
        chk("retire_cnt", o_retire_cnt, sb_cnt[rd_ptr % SBN]);
        chk("retire_ackR", o_ackR, sb_ack[rd_ptr % SBN]);
        chk("retire_latency", cyc, sb_due[rd_ptr % SBN]);
        rd_ptr++;
      end
    end else if (rd_ptr != wr_ptr && cyc > sb_due[rd_ptr % SBN]) begin
      chk("retire_missing", cyc, sb_due[rd_ptr % SBN]);
      rd_ptr++;
    end
  end

  // Ring environment model state.
  bit last_reqL = 0, ack_auto = 0, ret_auto = 0, rnd_valid = 0;
  int ack_max = 0, ack_tmr = -1, ring_tok = 0, n_launch = 0, n_drained = 0, max_inf = 0;

  task automatic toggle_req();
    i_reqR = ~i_reqR;
    if (ring_tok > 0) ring_tok--;
    mcnt = (mcnt + 1) % (1 << CW);
    sb_cnt[wr_ptr % SBN] = mcnt;
    sb_ack[wr_ptr % SBN] = i_reqR;
    sb_due[wr_ptr % SBN] = cyc + 3;
    wr_ptr++;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
    if (o_drained) n_drained++;
    if (int'(o_inflight) > max_inf) max_inf = int'(o_inflight);
    if (o_reqL != last_reqL) begin
      last_reqL = o_reqL;
      n_launch++;
      ring_tok++;
      if (ack_auto) ack_tmr = int'($urandom_range(ack_max, 0));
    end
    if (ack_tmr == 0) begin i_ackL = ~i_ackL; ack_tmr = -1; end
    else if (ack_tmr > 0) ack_tmr--;
    if (ret_auto && ring_tok > 0 && i_reqR == o_ackR && $urandom_range(3, 0) == 0) toggle_req();
    if (rnd_valid) i_launch_valid = 1'($urandom_range(1, 0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_reqL"}, o_reqL, 0);
    chk({tag, "_ackR"}, o_ackR, 0);
    chk({tag, "_retire"}, o_retire, 0);
    chk({tag, "_cnt"}, o_retire_cnt, 0);
    chk({tag, "_inflight"}, o_inflight, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_drained"}, o_drained, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_ready"}, o_launch_ready, 0);
  endtask

  task automatic do_reset(input bit check_during);
    i_rstn = 1'b0; i_ackL = 1'b0; i_reqR = 1'b0; i_launch_valid = 1'b0; i_enable = 1'b0;
    last_reqL = 0; ring_tok = 0; mcnt = 0; ack_tmr = -1;
    #1;
    if (check_during) chk_zero("in_reset");
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int base, rdy_after;
  bit done;
  initial begin
    // Reset, then a reset landing right after a launch.
    do_reset(0);
    tick();
    chk_zero("post_reset");
    i_enable = 1'b1;
    tick();
    i_launch_valid = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin tick(); done = o_reqL; end
    chk("midlaunch_reqL_seen", o_reqL, 1);
    do_reset(1);
    tick();
    chk_zero("after_mid_reset");

    // Single token round trip.
    i_enable = 1'b1;
    tick();
    chk("rt_busy", o_busy, 1);
    chk("rt_ready_run", o_launch_ready, 1);
    i_launch_valid = 1'b1;
    tick();
    i_launch_valid = 1'b0;
    chk("rt_reqL", o_reqL, 1);
    chk("rt_inflight1", o_inflight, 1);
    chk("rt_ready_drop", o_launch_ready, 0);
    repeat (3) tick();
    i_ackL = ~i_ackL;
    tick();
    chk("rt_ready_1edge", o_launch_ready, 0);
    tick();
    chk("rt_ready_2edge", o_launch_ready, 1);
    repeat (5) tick();
    toggle_req();
    repeat (2) tick();
    chk("rt_retire_early", o_retire, 0);
    tick();
    chk("rt_retire", o_retire, 1);
    chk("rt_ackR", o_ackR, 1);
    chk("rt_inflight0", o_inflight, 0);
    tick();
    chk("rt_retire_onecycle", o_retire, 0);
    chk("rt_cnt", o_retire_cnt, 1);

    // Saturation with an instantly acking IF and a silent WB.
    ack_auto = 1; ack_max = 0;
    base = n_launch; rdy_after = 0;
    i_launch_valid = 1'b1;
    repeat (40) begin
      tick();
      if (n_launch - base >= 4 && o_launch_ready) rdy_after++;
    end
    i_launch_valid = 1'b0;
    chk("sat_launches", n_launch - base, 4);
    chk("sat_inflight", o_inflight, 4);
    chk("sat_ready_after", rdy_after, 0);

    // Back to two in flight, then launch and retire on the same edge.
    toggle_req(); repeat (4) tick();
    toggle_req(); repeat (4) tick();
    chk("sim_pre_inflight", o_inflight, 2);
    base = n_launch;
    toggle_req();
    tick(); tick();
    i_launch_valid = 1'b1;
    tick();
    i_launch_valid = 1'b0;
    chk("sim_inflight", o_inflight, 2);
    chk("sim_retire", o_retire, 1);
    chk("sim_launched", n_launch - base, 1);
    repeat (3) tick();

    // One more to reach three in flight.
    base = n_launch;
    i_launch_valid = 1'b1;
    for (int k = 0; k < 20 && n_launch == base; k++) tick();
    i_launch_valid = 1'b0;
    chk("pre_drain_inflight", o_inflight, 3);
    repeat (3) tick();

    // Drain: launches requested but must not be taken.
    i_enable = 1'b0;
    tick();
    chk("drain_busy", o_busy, 1);
    i_launch_valid = 1'b1;
    base = n_launch; n_drained = 0;
    repeat (2) tick();
    repeat (3) begin toggle_req(); repeat (4) tick(); end
    repeat (4) tick();
    i_launch_valid = 1'b0;
    chk("drain_no_launch", n_launch - base, 0);
    chk("drain_pulses", n_drained, 1);
    chk("drain_idle", o_busy, 0);
    chk("drain_inflight", o_inflight, 0);

    // Randomised traffic; the retire counter wraps along the way.
    i_enable = 1'b1;
    ack_max = 4; ret_auto = 1; rnd_valid = 1;
    base = n_launch; max_inf = 0;
    repeat (600) tick();
    rnd_valid = 0; i_launch_valid = 1'b0;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      done = (ring_tok == 0) && (i_reqR == o_ackR) && (o_reqL == i_ackL) && (ack_tmr < 0);
    end
    chk("rand_settled", done, 1);
    repeat (6) tick();
    ret_auto = 0;
    chk("rand_inflight", o_inflight, 0);
    chk("rand_err", o_err, 0);
    chk("rand_cnt", o_retire_cnt, mcnt);
    chk("rand_max_inflight_ok", max_inf <= 4, 1);
    chk("rand_some_launches", (n_launch - base) > 10, 1);
    chk("rand_sb_drained", rd_ptr, wr_ptr);
    i_enable = 1'b0;
    repeat (4) tick();
    chk("rand_idle", o_busy, 0);

    // Protocol errors: retire with nothing in flight, then a stray acknowledge.
    toggle_req();
    repeat (4) tick();
    chk("err_retire_flag", o_err, 1);
    chk("err_retire_inflight", o_inflight, 0);
    chk("err_retire_ackR", o_ackR, i_reqR);
    repeat (10) tick();
    chk("err_sticky", o_err, 1);
    do_reset(0);
    tick();
    chk("err_cleared", o_err, 0);
    i_ackL = ~i_ackL;
    repeat (4) tick();
    chk("err_ack_flag", o_err, 1);
    chk("err_ack_inflight", o_inflight, 0);
    do_reset(0);
    tick();
    chk("final_err_cleared", o_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/click_sync_bridge.md
Name: click_sync_bridge

Overview:
- Clocked bridge between the synchronous control domain and the five-stage click-element ring of the async RV32I core.
- Transmitter side: injects tokens into the ring's left input. It drives the 2-phase request into IF and waits for the IF acknowledge.
- Receiver side: consumes tokens leaving WB. It detects request toggles on the WB right output and returns a 2-phase acknowledge.
- Also tracks tokens in flight, counts retirements and provides a controlled drain to quiescence.

Parameters:
- MAX_TOKENS, 4, maximum tokens in flight in the ring (1..15).
- SYNC_STAGES, 2, flop stages synchronising each async input (>=2).
- CNT_W, 16, width of the retire counter.

Ports:
- i_clk  input  1  system clock.
- i_rstn  input  1  asynchronous active-low reset. It is shared with the ring's i_rstn.
- i_enable  input  1  level; 1 = accept launches, 0 = drain and stop.
- i_launch_valid  input  1  launch request from the sync controller.
- o_launch_ready  output  1  launch accepted when valid && ready on a rising edge.
- o_reqL  output  1  2-phase request toggle to the ring's IF left request.
- i_ackL  input  1  async 2-phase acknowledge from the ring's IF left acknowledge.
- i_reqR  input  1  async 2-phase request from the ring's WB right request.
- o_ackR  output  1  2-phase acknowledge toggle back to the ring's WB right side.
- o_retire  output  1  one-cycle pulse per token retired at WB.
- o_retire_cnt  output  CNT_W  total retirements; wraps modulo 2^CNT_W.
- o_inflight  output  4  current tokens in flight.
- o_busy  output  1  state != IDLE.
- o_drained  output  1  one-cycle pulse on the DRAIN->IDLE transition.
- o_err  output  1  sticky protocol-error flag.

Behaviour:
- **Reset values:** all outputs 0, state IDLE, all synchroniser flops 0.
  - A reset mid-operation discards in-flight tokens.
  - The ring is reset by the same i_rstn, so both sides restart with req == ack == 0.
- **Synchronisers:** i_ackL and i_reqR each pass through SYNC_STAGES flops, giving ackL_s and reqR_s. reqR_s is registered once more as reqR_d for edge detection.
- **Left handshake state:** quiescent when o_reqL == ackL_s, pending otherwise.
- **o_launch_ready:** combinational, = (state == RUN) && quiescent && (o_inflight < MAX_TOKENS).
- **Launch:** when valid && ready is sampled at edge N:
  - o_reqL toggles at edge N.
  - o_inflight increments.
  - ready drops in the following cycle.
  - ready re-rises SYNC_STAGES edges after i_ackL toggles.
  - Only one outstanding left request is allowed at any time.
- **Retire:** when reqR_s != reqR_d:
  - o_retire is high for exactly one cycle.
  - o_ackR is registered to reqR_s in the same edge, so it mirrors the request.
  - o_retire_cnt increments.
  - o_inflight decrements.
  - Latency from the i_reqR toggle to o_retire is SYNC_STAGES+1 edges.
- **Launch and retire in the same cycle:** o_inflight is unchanged.
- **Inflight saturation:** at MAX_TOKENS, ready is held low and no further launches occur.
- **Errors (o_err set, sticky until reset):**
  - A retire with o_inflight == 0. o_inflight stays 0, o_retire still pulses and o_ackR still mirrors.
  - An ackL_s toggle while quiescent. The flop state is not corrected.
- **State machine:**
  - IDLE: goes to RUN when i_enable == 1.
  - RUN: goes to DRAIN when i_enable == 0. Launches are allowed only in RUN.
  - DRAIN: no launches; retires and acks continue. Goes to IDLE when o_inflight == 0 && quiescent. o_drained pulses on that edge.
  - i_enable returning to 1 during DRAIN has no effect until IDLE is reached. The next cycle then enters RUN.
- **Retire counter:** wraps from 2^CNT_W-1 to 0 with no error.
- **Retires in IDLE:** a retire arriving while in IDLE is still processed. It sets o_err because o_inflight == 0.

Test Plan:
- **Reset and idle:**
  - Stimulus: assert i_rstn=0 mid-launch, then release with i_enable=0.
  - Response: all outputs 0; o_launch_ready=0; o_busy=0.
- **Single token round trip:**
  - Stimulus: i_enable=1, one launch. The ring model toggles i_ackL 3 cycles later and i_reqR 10 cycles later (SYNC_STAGES=2).
  - Response: o_reqL=1; o_inflight=1. Ready re-rises 2 edges after the i_ackL toggle. o_retire pulses 3 edges after the i_reqR toggle; o_ackR=1; o_retire_cnt=1; o_inflight=0.
- **Saturation:**
  - Stimulus: i_launch_valid held high with an instantly-acking IF and WB never toggling.
  - Response: exactly 4 launches; o_inflight=4; o_launch_ready stays 0 thereafter.
- **Simultaneous launch and retire:**
  - Stimulus: with o_inflight=2, align a launch acceptance and a retire edge in the same cycle.
  - Response: o_inflight remains 2; o_retire_cnt increments by 1.
- **Drain:**
  - Stimulus: with 3 in flight, drop i_enable, then deliver 3 WB toggles.
  - Response: no further o_reqL toggles; o_drained pulses once after the 3rd retire; state IDLE; o_busy=0.
- **Protocol errors:**
  - Stimulus: toggle i_reqR with o_inflight=0; separately toggle i_ackL while quiescent.
  - Response: o_err=1 and remains 1 until reset; o_inflight stays 0.
